// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared AXI widths, master FSM states and AXI constants
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ID_BITS 4
`define AXI_ADDR_BITS 32
`define AXI_LEN_BITS 4
`define AXI_SIZE_BITS 3
`define AXI_DATA_BITS 32
`define AXI_STRB_BITS 4
`endif

package axi_master_pkg;
    localparam int ID_W   = `AXI_ID_BITS;
    localparam int ADDR_W = `AXI_ADDR_BITS;
    localparam int LEN_W  = `AXI_LEN_BITS;
    localparam int SIZE_W = `AXI_SIZE_BITS;
    localparam int DATA_W = `AXI_DATA_BITS;
    localparam int STRB_W = `AXI_STRB_BITS;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE} state_e;
    // A protocol error only upgrades an otherwise clean response.
    function automatic logic [1:0] merge_resp(input logic [1:0] cap, input logic err);
        return (err && cap == AXI_RESP_OKAY) ? AXI_RESP_SLVERR : cap;
    endfunction
endpackage

// File: rtl/axi_beat_counter.sv
// axi_beat_counter: burst beat index with last-beat detect, shared by read and write paths
// Ports: clk/rst, clr (restart at beat 0), inc (beat handshake), len (beats-1), is_last (cnt==len)
module axi_beat_counter
    import axi_master_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             is_last
);
    logic [LEN_W-1:0] cnt_d, cnt_q;
    always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign is_last = cnt_q == len;
endmodule

// File: rtl/axi_master_wrapper.sv
// axi_master_wrapper: bridges a simple CPU request port onto single AXI4 read or write bursts
// Ports: ACLK/ARESET; CPU request req_*; write beats wr_*; read beats rd_*; completion done/resp;
// AXI master channels AR/R/AW/W/B (*_M). One transaction in flight at a time.
module axi_master_wrapper
    import axi_master_pkg::*;
#(
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [SIZE_W-1:0] req_size,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              done,
    output logic [1:0]        resp,
    output logic [ID_W-1:0]   ARID_M,
    output logic [ADDR_W-1:0] ARADDR_M,
    output logic [LEN_W-1:0]  ARLEN_M,
    output logic [SIZE_W-1:0] ARSIZE_M,
    output logic [1:0]        ARBURST_M,
    output logic              ARVALID_M,
    input  logic              ARREADY_M,
    input  logic [ID_W-1:0]   RID_M,
    input  logic [DATA_W-1:0] RDATA_M,
    input  logic [1:0]        RRESP_M,
    input  logic              RLAST_M,
    input  logic              RVALID_M,
    output logic              RREADY_M,
    output logic [ID_W-1:0]   AWID_M,
    output logic [ADDR_W-1:0] AWADDR_M,
    output logic [LEN_W-1:0]  AWLEN_M,
    output logic [SIZE_W-1:0] AWSIZE_M,
    output logic [1:0]        AWBURST_M,
    output logic              AWVALID_M,
    input  logic              AWREADY_M,
    output logic [DATA_W-1:0] WDATA_M,
    output logic [STRB_W-1:0] WSTRB_M,
    output logic              WLAST_M,
    output logic              WVALID_M,
    input  logic              WREADY_M,
    input  logic [ID_W-1:0]   BID_M,
    input  logic [1:0]        BRESP_M,
    input  logic              BVALID_M,
    output logic              BREADY_M
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [1:0] cap_q, cap_d;
    logic err_q, err_d;
    logic req_ready_q, req_ready_d, arvalid_q, arvalid_d, awvalid_q, awvalid_d;
    logic bready_q, bready_d, done_q, done_d;
    logic is_last, cnt_clr, r_hs, w_hs;
    assign r_hs = state_q == RDATA && RVALID_M && rd_ready;
    assign w_hs = state_q == WDATA && wr_valid && WREADY_M;
    axi_beat_counter u_cnt (
        .clk(ACLK), .rst(ARESET), .clr(cnt_clr), .inc(r_hs | w_hs), .len(len_q), .is_last(is_last)
    );
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        len_d = len_q;
        size_d = size_q;
        cap_d = cap_q;
        err_d = err_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                addr_d = req_addr;
                len_d = req_len;
                size_d = req_size;
                cap_d = AXI_RESP_OKAY;
                err_d = 1'b0;
                cnt_clr = 1'b1;
                state_d = req_write ? WADDR : RADDR;
            end
            RADDR: if (ARREADY_M) state_d = RDATA;
            // RLAST disagreeing with the beat count covers both early and missing RLAST.
            RDATA: if (r_hs) begin
                err_d = err_q | (RID_M != MASTER_ID) | (RRESP_M != AXI_RESP_OKAY) | (RLAST_M != is_last);
                cap_d = cap_q == AXI_RESP_OKAY ? RRESP_M : cap_q;
                state_d = (RLAST_M || is_last) ? DONE : RDATA;
            end
            WADDR: if (AWREADY_M) state_d = WDATA;
            WDATA: if (w_hs && is_last) state_d = WRESP;
            WRESP: if (BVALID_M) begin
                cap_d = BRESP_M;
                err_d = err_q | (BID_M != MASTER_ID);
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Handshake-facing outputs are registered from the next state so they rise with it.
        req_ready_d = state_d == IDLE;
        arvalid_d = state_d == RADDR;
        awvalid_d = state_d == WADDR;
        bready_d = state_d == WRESP;
        done_d = state_d == DONE;
    end
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            cap_q <= AXI_RESP_OKAY;
            err_q <= 1'b0;
            req_ready_q <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            len_q <= len_d;
            size_q <= size_d;
            cap_q <= cap_d;
            err_q <= err_d;
            req_ready_q <= req_ready_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            bready_q <= bready_d;
            done_q <= done_d;
        end
    end
    assign req_ready = req_ready_q;
    assign done = done_q;
    assign resp = done_q ? merge_resp(cap_q, err_q) : AXI_RESP_OKAY;
    assign ARID_M = MASTER_ID;
    assign ARADDR_M = addr_q;
    assign ARLEN_M = len_q;
    assign ARSIZE_M = size_q;
    assign ARBURST_M = AXI_BURST_INCR;
    assign ARVALID_M = arvalid_q;
    assign AWID_M = MASTER_ID;
    assign AWADDR_M = addr_q;
    assign AWLEN_M = len_q;
    assign AWSIZE_M = size_q;
    assign AWBURST_M = AXI_BURST_INCR;
    assign AWVALID_M = awvalid_q;
    assign RREADY_M = state_q == RDATA && rd_ready;
    assign rd_valid = state_q == RDATA && RVALID_M;
    assign rd_last = state_q == RDATA && RLAST_M;
    assign rd_data = RDATA_M;
    assign WVALID_M = state_q == WDATA && wr_valid;
    assign WLAST_M = state_q == WDATA && is_last;
    assign WDATA_M = wr_data;
    assign WSTRB_M = wr_strb;
    assign wr_ready = state_q == WDATA && WREADY_M;
    assign BREADY_M = bready_q;
endmodule

// File: tb/tb_axi_master_wrapper.sv
// tb_axi_master_wrapper: table-driven and randomized bursts against a CPU/slave model
module tb_axi_master_wrapper;
    import axi_master_pkg::*;
    localparam logic [ID_W-1:0] MID = ID_W'(5);
    logic ACLK = 1'b0, ARESET;
    logic req_valid, req_ready, req_write, wr_valid, wr_ready, rd_valid, rd_last, rd_ready, done;
    logic [ADDR_W-1:0] req_addr, ARADDR_M, AWADDR_M;
    logic [LEN_W-1:0] req_len, ARLEN_M, AWLEN_M;
    logic [SIZE_W-1:0] req_size, ARSIZE_M, AWSIZE_M;
    logic [DATA_W-1:0] wr_data, rd_data, RDATA_M, WDATA_M;
    logic [STRB_W-1:0] wr_strb, WSTRB_M;
    logic [1:0] resp, ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
    logic [ID_W-1:0] ARID_M, AWID_M, RID_M, BID_M;
    logic ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M, AWVALID_M, AWREADY_M;
    logic WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;

    axi_master_wrapper #(.MASTER_ID(MID)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .resp(resp),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
        .BREADY_M(BREADY_M)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit wr;
        logic [31:0] addr;
        int len;
        int size;
        int a_delay;
        int last_at;
        int bad_beat;
        bit bad_id;
        int stall_at;
        int stall_len;
        bit wgap;
        int wblk_lo;
        int wblk_hi;
        logic [1:0] bresp;
        logic [3:0] strb;
        int rst_beat;
        logic [31:0] dbase;
        int exp_beats;
        logic [1:0] exp_resp;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input int len, input logic [31:0] dbase);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.size = 2; v.a_delay = 0; v.last_at = len;
        v.bad_beat = -1; v.bad_id = 0; v.stall_at = -1; v.stall_len = 0; v.wgap = 0;
        v.wblk_lo = -1; v.wblk_hi = -1; v.bresp = 2'b00; v.strb = 4'hF; v.rst_beat = -1;
        v.dbase = dbase; v.exp_beats = len + 1; v.exp_resp = 2'b00;
        return v;
    endfunction

    // Expected outcome from the protocol rules: completed beats and the final response.
    function automatic void model(input vec_t v, output int beats, output logic [1:0] r);
        bit err;
        if (v.wr) begin
            beats = v.len + 1;
            r = v.bresp != 2'b00 ? v.bresp : (v.bad_id ? 2'b10 : 2'b00);
        end else begin
            beats = (v.last_at < v.len ? v.last_at : v.len) + 1;
            err = v.last_at != v.len || v.bad_id || (v.bad_beat >= 0 && v.bad_beat < beats);
            r = err ? 2'b10 : 2'b00;
        end
    endfunction

    task automatic idle();
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_size = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
        ARREADY_M = 0; RID_M = '0; RDATA_M = '0; RRESP_M = '0; RLAST_M = 0; RVALID_M = 0;
        AWREADY_M = 0; WREADY_M = 0; BID_M = '0; BRESP_M = '0; BVALID_M = 0;
    endtask

    task automatic quiet();
        check("rst_arvalid", 64'(ARVALID_M), 0);
        check("rst_awvalid", 64'(AWVALID_M), 0);
        check("rst_wvalid", 64'(WVALID_M), 0);
        check("rst_wr_ready", 64'(wr_ready), 0);
        check("rst_rready", 64'(RREADY_M), 0);
        check("rst_bready", 64'(BREADY_M), 0);
        check("rst_rd_valid", 64'(rd_valid), 0);
        check("rst_done", 64'(done), 0);
        check("rst_resp", 64'(resp), 0);
        check("rst_req_ready", 64'(req_ready), 0);
    endtask

    task automatic run(input vec_t v);
        int cyc = 0, aw = 0, k = 0, blk = 0, bw = 0, stall_left = v.stall_len;
        bit a_done = 0, w_done = 0, b_done = 0, dv = 0, rv = 0, bv = 0, got = 0, rst_hit = 0;
        @(negedge ACLK);
        req_valid = 1; req_write = v.wr; req_addr = v.addr;
        req_len = LEN_W'(v.len); req_size = SIZE_W'(v.size);
        #1 check("req_ready_idle", 64'(req_ready), 1);
        dv = v.wr;
        while (!got && !rst_hit && cyc < 300) begin
            @(negedge ACLK);
            cyc++;
            req_valid = cyc == 2;
            req_write = ~v.wr; req_addr = $urandom; req_len = LEN_W'($urandom);
            if (v.wr) begin
                if (v.rst_beat >= 0 && k == v.rst_beat) begin
                    rst_hit = 1;
                    ARESET = 1;
                end
                AWREADY_M = AWVALID_M && aw >= v.a_delay;
                if (!dv && k <= v.len) dv = !v.wgap || (cyc % 2 == 0);
                wr_valid = dv; wr_data = v.dbase + 32'(k); wr_strb = v.strb;
                WREADY_M = !(a_done && k >= v.wblk_lo && k <= v.wblk_hi && blk < 2);
                if (!WREADY_M) blk++;
                if (w_done && !b_done && !bv) begin
                    if (bw >= v.a_delay) bv = 1;
                    else bw++;
                end
                BVALID_M = bv; BRESP_M = v.bresp; BID_M = v.bad_id ? ~MID : MID;
                #1;
                if (!rst_hit) begin
                    if (!a_done) begin
                        if (dv) begin
                            check("no_w_before_aw", 64'(WVALID_M), 0);
                            check("no_wready_before_aw", 64'(wr_ready), 0);
                        end
                    end else if (!w_done && dv && wr_ready) begin
                        check("wvalid", 64'(WVALID_M), 1);
                        check("wdata", 64'(WDATA_M), 64'(v.dbase + 32'(k)));
                        check("wstrb", 64'(WSTRB_M), 64'(v.strb));
                        check("wlast", 64'(WLAST_M), 64'(k == v.len));
                        k++; dv = 0; blk = 0;
                        if (k > v.len) w_done = 1;
                    end else if (!w_done && dv) begin
                        check("wvalid_hold", 64'(WVALID_M), 1);
                        check("wr_ready_follow", 64'(wr_ready), 64'(WREADY_M));
                    end
                    if (AWVALID_M) begin
                        check("awaddr", 64'(AWADDR_M), 64'(v.addr));
                        check("awlen", 64'(AWLEN_M), 64'(v.len));
                        check("awsize", 64'(AWSIZE_M), 64'(v.size));
                        check("awburst", 64'(AWBURST_M), 1);
                        check("awid", 64'(AWID_M), 64'(MID));
                        aw++;
                        if (AWREADY_M) a_done = 1;
                    end
                    if (bv) begin
                        check("bready", 64'(BREADY_M), 1);
                        if (BREADY_M) begin bv = 0; b_done = 1; end
                    end
                end
            end else begin
                ARREADY_M = ARVALID_M && aw >= v.a_delay;
                rd_ready = !(a_done && k == v.stall_at && stall_left > 0);
                if (!rd_ready) stall_left--;
                if (a_done && !rv) rv = $urandom_range(0, 3) != 0;
                RVALID_M = rv; RDATA_M = v.dbase + 32'(k); RLAST_M = k == v.last_at;
                RID_M = (v.bad_id && k == 0) ? ~MID : MID;
                RRESP_M = k == v.bad_beat ? 2'b10 : 2'b00;
                #1;
                check("rready", 64'(RREADY_M), 64'(a_done && k < v.exp_beats && rd_ready));
                if (rv && RREADY_M) begin
                    check("rd_valid", 64'(rd_valid), 1);
                    check("rd_data", 64'(rd_data), 64'(v.dbase + 32'(k)));
                    check("rd_last", 64'(rd_last), 64'(k == v.last_at));
                    k++; rv = 0;
                end
                if (ARVALID_M) begin
                    check("araddr", 64'(ARADDR_M), 64'(v.addr));
                    check("arlen", 64'(ARLEN_M), 64'(v.len));
                    check("arsize", 64'(ARSIZE_M), 64'(v.size));
                    check("arburst", 64'(ARBURST_M), 1);
                    check("arid", 64'(ARID_M), 64'(MID));
                    aw++;
                    if (ARREADY_M) a_done = 1;
                end
            end
            if (!rst_hit && cyc == 2) check("req_ignored_busy", 64'(req_ready), 0);
            if (!rst_hit && done) begin
                got = 1;
                check("resp", 64'(resp), 64'(v.exp_resp));
                check("beats", 64'(k), 64'(v.exp_beats));
                check("addr_valid_cycles", 64'(aw), 64'(v.a_delay + 1));
            end
        end
        if (rst_hit) begin
            @(negedge ACLK);
            quiet();
            check("beats_before_reset", 64'(k), 64'(v.exp_beats));
            ARESET = 0;
            idle();
            @(negedge ACLK);
            check("req_ready_after_reset", 64'(req_ready), 1);
        end else if (got) begin
            idle();
            @(negedge ACLK);
            check("done_one_cycle", 64'(done), 0);
            check("req_ready_after_done", 64'(req_ready), 1);
        end else begin
            check("timeout_done", 0, 1);
            idle();
            ARESET = 1;
            @(negedge ACLK);
            ARESET = 0;
            @(negedge ACLK);
        end
    endtask

    initial begin
        vec_t v;
        idle();
        wr_valid = 1; RVALID_M = 1; rd_ready = 1; WREADY_M = 1;
        ARESET = 1;
        repeat (2) @(negedge ACLK);
        quiet();
        ARESET = 0;
        idle();
        @(negedge ACLK);
        check("req_ready_out_of_reset", 64'(req_ready), 1);

        tbl[0] = mk(0, 32'h0000_1000, 3, 32'hA0);        tbl[0].a_delay = 2;
        tbl[1] = mk(1, 32'h0000_2000, 0, 32'hDEADBEEF);  tbl[1].strb = 4'b0011;
        tbl[2] = mk(1, 32'h0000_3000, 7, 32'h1111_0000); tbl[2].wgap = 1; tbl[2].wblk_lo = 2; tbl[2].wblk_hi = 3;
        tbl[3] = mk(0, 32'h0000_4000, 3, 32'hB0);        tbl[3].last_at = 2; tbl[3].exp_beats = 3; tbl[3].exp_resp = 2'b10;
        tbl[4] = mk(0, 32'h0000_5000, 3, 32'hC0);        tbl[4].stall_at = 1; tbl[4].stall_len = 5;
        tbl[5] = mk(1, 32'h0000_6000, 7, 32'h2222_0000); tbl[5].rst_beat = 3; tbl[5].exp_beats = 3;
        tbl[6] = mk(0, 32'h0000_7000, 1, 32'hD0);
        tbl[7] = mk(0, 32'h0000_8000, 15, 32'hE000);     tbl[7].a_delay = 1; tbl[7].exp_beats = 16;
        tbl[8] = mk(1, 32'h0000_9000, 2, 32'h3300);      tbl[8].bresp = 2'b11; tbl[8].exp_resp = 2'b11;
        tbl[9] = mk(1, 32'h0000_A000, 1, 32'h4400);      tbl[9].bad_id = 1; tbl[9].exp_resp = 2'b10;
        tbl[10] = mk(0, 32'h0000_B000, 2, 32'h5500);     tbl[10].bad_beat = 1; tbl[10].exp_resp = 2'b10;
        tbl[11] = mk(0, 32'h0000_C000, 0, 32'h6600);     tbl[11].last_at = 5; tbl[11].exp_beats = 1; tbl[11].exp_resp = 2'b10;
        tbl[12] = mk(0, 32'h0000_D000, 2, 32'h7700);     tbl[12].bad_id = 1; tbl[12].exp_resp = 2'b10;
        tbl[13] = mk(1, 32'h0000_E000, 15, 32'h8800);    tbl[13].a_delay = 3; tbl[13].exp_beats = 16;
        for (int i = 0; i < 14; i++) run(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            v = mk(1'($urandom), $urandom, int'($urandom_range(0, 15)), $urandom);
            v.size = int'($urandom_range(0, 2));
            v.a_delay = int'($urandom_range(0, 3));
            v.bad_id = $urandom_range(0, 5) == 0;
            if (v.wr) begin
                v.wgap = 1'($urandom);
                v.wblk_lo = int'($urandom_range(0, 15));
                v.wblk_hi = v.wblk_lo + int'($urandom_range(0, 2));
                v.strb = 4'($urandom);
                v.bresp = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                v.last_at = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : v.len;
                v.bad_beat = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 15)) : -1;
                v.stall_at = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 15)) : -1;
                v.stall_len = int'($urandom_range(1, 4));
            end
            model(v, v.exp_beats, v.exp_resp);
            run(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_master_wrapper.md
Name: axi_master_wrapper

Overview:
- AXI4 master-side bridge: converts a simple CPU/cache-side request interface into single AXI read or write bursts.
- Drives AR/R and AW/W/B channels toward the AXI bus/crossbar; memory-side wrappers respond on the slave side.
- One transaction outstanding at a time; read and write never overlap.

Parameters:
- MASTER_ID, 0, value driven on ARID_M/AWID_M (width `AXI_ID_BITS); also the expected RID_M/BID_M.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous, active-high
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  `AXI_ADDR_BITS  byte start address
- req_len  in  `AXI_LEN_BITS  beats minus one
- req_size  in  `AXI_SIZE_BITS  beat size
- wr_data  in  `AXI_DATA_BITS  write beat data
- wr_strb  in  `AXI_STRB_BITS  write byte strobes, 1 = byte enabled
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat consumed
- rd_data  out  `AXI_DATA_BITS  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat
- rd_ready  in  1  CPU accepts read beat
- done  out  1  one-cycle pulse at transaction end
- resp  out  2  final response, valid with done
- AR*/R*/AW*/W*/B* master ports (suffix _M): ID, ADDR, LEN, SIZE, BURST, VALID, READY, DATA, STRB, LAST, RESP. Widths come from AXI_define.svh.

Behaviour:
- Reset applies on ACLK edge with ARESET=1. After reset: state IDLE; all *VALID_M, RREADY_M, BREADY_M, req_ready, wr_ready, rd_valid, done = 0; resp = 0; counters = 0.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE: req_ready=1. On accept, register addr/len/size/write, clear beat cnt. Go to RADDR if read, else WADDR. Accept costs 1 cycle, so ARVALID_M/AWVALID_M rise the next cycle.
- RADDR: ARVALID_M=1. ARADDR/ARLEN/ARSIZE/ARID come from registers; ARBURST=INCR (2'b01). These values stay stable until ARREADY_M. On handshake go to RDATA.
- RDATA: RREADY_M=rd_ready. rd_valid=RVALID_M. rd_data=RDATA_M. rd_last=RLAST_M. Zero-latency pass-through.
  - Beat handshake increments cnt.
  - Sticky error is set on any of: RID_M≠MASTER_ID, RRESP_M≠OKAY, RLAST_M while cnt≠len, or beat at cnt==len without RLAST_M.
  - The last beat completes on (RLAST_M | cnt==len) & handshake, then go to DONE.
- WADDR: AWVALID_M=1, analogous to RADDR. W channel is idle here; no write data before the address handshake. Then go to WDATA.
- WDATA: WVALID_M=wr_valid, WDATA_M=wr_data, WSTRB_M=wr_strb, wr_ready=WREADY_M, WLAST_M=(cnt==len). On handshake cnt++. The handshake at cnt==len goes to WRESP.
- WRESP: BREADY_M=1. On BVALID_M, capture BRESP_M; set error if BID_M≠MASTER_ID. Then go to DONE.
- DONE: done=1 for exactly one cycle. resp = captured/merged response (SLVERR 2'b10 if sticky error and captured resp was OKAY). Then go to IDLE. req_ready=0 in DONE; earliest next accept is the following cycle.
- Len 0: a single beat with LAST asserted on the first beat.
- Max len: 4-bit counter, up to 16 beats; no wrap.
- CPU stall: valid signals held without change while READY low (AXI stability rule). Master never drops a VALID once raised.
- ARESET mid-transaction: returns to IDLE immediately and all outputs go to their reset values. The bus is assumed reset together with the master.
- req_valid while busy: ignored (req_ready=0).

Decomposition:
- Shared package axi_master_pkg: state enum typedef, AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR constants.
- Widths come from existing AXI_define.svh macros.
- Sub-module axi_beat_counter (load/clear, inc on handshake, is_last = cnt==len) is natural and shared by R and W paths.

Test Plan:
- Read, len=3, addr 0x0000_1000, slave returns 0xA0..0xA3 with ARREADY delayed 2 cycles -> ARVALID held stable 3 cycles; rd_data A0..A3 with rd_last on 4th; done pulse, resp=00.
- Write, len=0, data 0xDEADBEEF, strb 4'b0011 -> AWLEN=0; WLAST=1 on the only beat; BREADY high until BVALID; done, resp=00.
- Write, len=7, wr_valid toggled every other cycle and WREADY low for beats 2-3 -> exactly 8 W handshakes; WLAST only on 8th; no data dropped/duplicated.
- Read, len=3, slave asserts RLAST on beat 2 -> done after beat 2, resp=2'b10.
- Read with rd_ready held low 5 cycles mid-burst -> RREADY_M low; beat order preserved after release.
- ARESET pulsed during WDATA beat 3 -> next cycle all VALID/READY=0, state IDLE, req_ready=1; a subsequent read completes normally.
